// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline register.
// Optional stall counter is enabled by defining PIPE_STALL_CNT_EN.
package pipe_pkg;

    localparam int STALL_CNT_W = 32;

    // Upper bound on DEPTH. The stage-valid vector is a fixed-width type so it
    // can live in the package. Bits at and above DEPTH are always zero.
    localparam int MAX_DEPTH = 64;

    typedef logic [MAX_DEPTH-1:0] stage_vec_t;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int count_full(input stage_vec_t v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic stage: a data flop with load enable plus a valid flop.
// The stage takes a new word when it is empty or its own word is leaving.
// Flush clears only the valid bit and leaves the data untouched.
module pipe_stage #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic             adv_out,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             w_open;

    assign w_open = !r_full || adv_out;

    // Valid bit and data register. A full stage that is not draining holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
            r_data <= RESET_VAL;
        end else begin
            if (flush) begin
                r_full <= 1'b0;
            end else if (w_open) begin
                r_full <= src_valid;
            end
            if (!flush && w_open && src_valid) begin
                r_data <= src_data;
            end
        end
    end

    assign full = r_full;
    assign data = r_data;

endmodule

// File: rtl/pipe_reg_elastic.sv
// DEPTH-stage, WIDTH-bit elastic pipeline register with valid/ready on both
// sides, synchronous flush and a registered occupancy count.
// Define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
// DEPTH must be between 1 and pipe_pkg::MAX_DEPTH.
module pipe_reg_elastic
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [occ_w(DEPTH)-1:0]   occupancy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]    stall_cnt
`endif
);

    localparam int OCC_W = occ_w(DEPTH);

    logic [DEPTH-1:0] w_full;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_src_vld;
    logic [WIDTH-1:0] w_data     [DEPTH];
    logic [WIDTH-1:0] w_src_data [DEPTH];
    logic             w_in_ready;
    stage_vec_t       w_full_nxt;
    logic [OCC_W-1:0] r_occ;

    // Ready chain in closed form: a full stage advances when the consumer is
    // ready or any later stage is empty, so no signal depends on its own bits.
    always_comb begin
        logic v_take;
        v_take = out_ready;
        w_adv  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_adv[i] = w_full[i] && v_take;
            v_take   = v_take || !w_full[i];
        end
    end

    assign w_in_ready = !reset && !flush && (!w_full[0] || w_adv[0]);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_src_vld[gi]  = in_valid && w_in_ready;
                assign w_src_data[gi] = in_data;
            end else begin : g_body
                assign w_src_vld[gi]  = w_full[gi-1];
                assign w_src_data[gi] = w_data[gi-1];
            end

            pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk       (clk),
                .reset     (reset),
                .flush     (flush),
                .src_valid (w_src_vld[gi]),
                .src_data  (w_src_data[gi]),
                .adv_out   (w_adv[gi]),
                .full      (w_full[gi]),
                .data      (w_data[gi])
            );
        end
    endgenerate

    // Predict the stage valid bits after the coming edge, mirroring each stage.
    always_comb begin
        w_full_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (reset || flush) begin
                w_full_nxt[i] = 1'b0;
            end else if (!w_full[i] || w_adv[i]) begin
                w_full_nxt[i] = w_src_vld[i];
            end else begin
                w_full_nxt[i] = w_full[i];
            end
        end
    end

    // Occupancy register tracks the popcount of the full bits edge by edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ <= '0;
        end else begin
            r_occ <= OCC_W'(count_full(w_full_nxt));
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Saturating count of cycles where output is valid but not taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_full[DEPTH-1] && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = w_full[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];
    assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed bench for pipe_reg_elastic (WIDTH=8, DEPTH=3) with a FIFO
// scoreboard. Stall counter checks are built when PIPE_STALL_CNT_EN is set.
module tb_pipe_reg_elastic;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0]      stall_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [WIDTH-1:0] q_exp [$];

    pipe_reg_elastic #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL ('0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: score handshakes at the negedge, advance, check occupancy.
    task automatic step();
        logic [WIDTH-1:0] v_exp;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                v_exp = q_exp.pop_front();
                chk("out_data", 32'(out_data), 32'(v_exp));
            end
        end
        if (in_valid && in_ready) q_exp.push_back(in_data);
        if (reset || flush) q_exp.delete();
        @(posedge clk);
        #1;
        chk("occupancy", 32'(occupancy), 32'(q_exp.size()));
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b0;

        // Reset held two cycles with a word offered.
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'h00);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Streaming at full throughput.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h3C; #1; chk("stream_in_ready0", 32'(in_ready), 32'd1); step();
        chk("lat_out_valid_e1", 32'(out_valid), 32'd0);
        in_data   = 8'h5A; #1; chk("stream_in_ready1", 32'(in_ready), 32'd1); step();
        chk("lat_out_valid_e2", 32'(out_valid), 32'd0);
        in_data   = 8'hC3; #1; chk("stream_in_ready2", 32'(in_ready), 32'd1); step();
        in_valid  = 1'b0;
        chk("lat_out_valid_e3", 32'(out_valid), 32'd1);
        chk("lat_out_data_e3",  32'(out_data),  32'h3C);
        step();
        step();
        step();
        chk("drained_out_valid", 32'(out_valid), 32'd0);
        chk("empty_holds_data",  32'(out_data),  32'hC3);

        // Backpressure: fill, stall the fourth word, then accept and drain together.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11; step();
        in_data   = 8'h22; step();
        in_data   = 8'h33; step();
        in_data   = 8'h44;
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("full_hold_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_data",      32'(out_data), 32'h11);
        out_ready = 1'b1;
        #1;
        chk("full_drain_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Flush with two words in flight and a word offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h01; step();
        in_data   = 8'h02; step();
        flush     = 1'b1;
        in_data   = 8'h77;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step();
        step();
        step();
        step();
        chk("flush_no_77", 32'(out_valid), 32'd0);

        // Reset and flush together mid-stream, then a fresh word.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA; step();
        in_data   = 8'hBB; step();
        in_data   = 8'hCC; step();
        in_valid  = 1'b0;
        reset     = 1'b1;
        flush     = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        chk("rf_out_valid", 32'(out_valid), 32'd0);
        chk("rf_out_data",  32'(out_data),  32'h00);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h9E;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("rf_9e_valid", 32'(out_valid), 32'd1);
        step();
        chk("rf_9e_gone", 32'(out_valid), 32'd0);

`ifdef PIPE_STALL_CNT_EN
        reset = 1'b1;
        step();
        reset     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hD1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("sc_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) step();
        chk("sc_five", stall_cnt, 32'd5);
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        chk("sc_after_flush", stall_cnt, 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("sc_after_reset", stall_cnt, 32'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hD2;
        step();
        in_valid = 1'b0;
        step();
        step();
        dut.r_stall_cnt = 32'hFFFF_FFFD;
        for (int i = 0; i < 4; i++) step();
        chk("sc_saturate", stall_cnt, 32'hFFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
